// File: rtl/ppu_line_buf.sv
// Double-buffered scanline store: the renderer fills one bank while ppu_vga reads the other.
// Banks swap at the end of each displayed NES line once the write bank holds a full line.
module ppu_line_buf #(
    parameter int          LINE_W    = 256,
    parameter int          LINE_H    = 240,
    parameter logic [5:0]  BLANK_IDX = 6'h0f
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  nes_x_in,
    input  logic [9:0]  nes_y_in,
    input  logic [9:0]  nes_y_next_in,
    input  logic        pix_pulse_in,
    input  logic        wr_valid_in,
    input  logic [5:0]  wr_idx_in,
    output logic        wr_ready_out,
    output logic [7:0]  req_y_out,
    output logic [5:0]  sys_palette_idx_out,
    output logic        underrun_out
);

    localparam int AW = $clog2(LINE_W);
    localparam logic [9:0] X_LAST = 10'(LINE_W - 1);
    localparam logic [9:0] X_END  = 10'(LINE_W);
    localparam logic [9:0] Y_END  = 10'(LINE_H);

    typedef logic [AW:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(LINE_W - 1);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t      r_state, w_state_next;
    logic        r_wr_bank, w_wr_bank_next;
    cnt_t        r_wr_cnt, w_wr_cnt_next;
    logic [7:0]  r_req_y, w_req_y_next;
    logic        r_rd_valid, w_rd_valid_next;
    logic        r_underrun, w_underrun_next;
    logic        r_rd_blank;
    logic [5:0]  r_rd_data;
    logic [5:0]  r_mem [0:2*LINE_W-1];

    logic        w_swap_pt;
    logic        w_wr_en;
    logic        w_last_wr;
    logic [7:0]  w_req_y_new;
    logic        w_rd_blank;
    logic [AW:0] w_wr_addr;
    logic [AW:0] w_rd_addr;

    assign w_swap_pt = pix_pulse_in && (nes_x_in == X_LAST) &&
                       (nes_y_next_in != nes_y_in) && (nes_y_next_in < Y_END);
    assign w_wr_en   = (r_state == S_FILL) && wr_valid_in;
    assign w_last_wr = w_wr_en && (r_wr_cnt == CNT_LAST);
    assign w_req_y_new = ((nes_y_next_in + 10'd1) == Y_END) ? 8'd0 : nes_y_next_in[7:0] + 8'd1;
    assign w_rd_blank  = (nes_x_in >= X_END) || (nes_y_in >= Y_END) || !r_rd_valid;
    assign w_wr_addr   = {r_wr_bank, r_wr_cnt[AW-1:0]};
    assign w_rd_addr   = {~r_wr_bank, nes_x_in[AW-1:0]};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_FILL;
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_req_y    <= 8'd0;
            r_rd_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_rd_blank <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_wr_bank  <= w_wr_bank_next;
            r_wr_cnt   <= w_wr_cnt_next;
            r_req_y    <= w_req_y_next;
            r_rd_valid <= w_rd_valid_next;
            r_underrun <= w_underrun_next;
            r_rd_blank <= w_rd_blank;
        end
    end

    // A final write landing on the swap clock completes the line, so it swaps rather than underruns.
    always_comb begin
        w_state_next    = r_state;
        w_wr_bank_next  = r_wr_bank;
        w_wr_cnt_next   = r_wr_cnt;
        w_req_y_next    = r_req_y;
        w_rd_valid_next = r_rd_valid;
        w_underrun_next = 1'b0;
        wr_ready_out    = 1'b0;
        case (r_state)
            S_FILL: begin
                wr_ready_out = 1'b1;
                if (w_swap_pt) begin
                    w_wr_cnt_next = '0;
                    w_req_y_next  = w_req_y_new;
                    if (w_last_wr) begin
                        w_wr_bank_next  = ~r_wr_bank;
                        w_rd_valid_next = 1'b1;
                    end else begin
                        w_underrun_next = 1'b1;
                    end
                end else if (w_wr_en) begin
                    w_wr_cnt_next = r_wr_cnt + cnt_t'(1);
                    if (w_last_wr) begin
                        w_state_next = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (w_swap_pt) begin
                    w_state_next    = S_FILL;
                    w_wr_bank_next  = ~r_wr_bank;
                    w_rd_valid_next = 1'b1;
                    w_wr_cnt_next   = '0;
                    w_req_y_next    = w_req_y_new;
                end
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    // Bank storage has no reset; the blank flag masks stale read data.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= wr_idx_in;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    assign sys_palette_idx_out = r_rd_blank ? BLANK_IDX : r_rd_data;
    assign req_y_out           = r_req_y;
    assign underrun_out        = r_underrun;

endmodule

// File: tb/tb_ppu_line_buf.sv
// Scoreboard bench for ppu_line_buf: stimulus queues expected values tagged with a cycle,
// a negedge monitor compares whatever is due on that cycle.
module tb_ppu_line_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] nes_x, nes_y, nes_y_next;
    logic       pulse;
    logic       wr_valid;
    logic [5:0] wr_idx;
    logic       wr_ready;
    logic [7:0] req_y;
    logic [5:0] pix;
    logic       underrun;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    localparam int K_PIX = 0, K_RDY = 1, K_UND = 2, K_REQ = 3;

    ppu_line_buf dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .nes_x_in           (nes_x),
        .nes_y_in           (nes_y),
        .nes_y_next_in      (nes_y_next),
        .pix_pulse_in       (pulse),
        .wr_valid_in        (wr_valid),
        .wr_idx_in          (wr_idx),
        .wr_ready_out       (wr_ready),
        .req_y_out          (req_y),
        .sys_palette_idx_out(pix),
        .underrun_out       (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    // Monitor: compare every entry due this cycle; overdue entries count as failures.
    always @(negedge clk) begin
        exp_t       keep[$];
        logic [7:0] act;
        keep = {};
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) begin
                case (sb_q[i].kind)
                    K_PIX:   act = {2'b00, pix};
                    K_RDY:   act = {7'd0, wr_ready};
                    K_UND:   act = {7'd0, underrun};
                    default: act = req_y;
                endcase
                checks++;
                if (act !== sb_q[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%0h required=%0h", sb_q[i].name, cyc, act, sb_q[i].val);
                end else begin
                    $display("ok   %s cyc=%0d value=%0h", sb_q[i].name, cyc, act);
                end
            end else if (sb_q[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s overdue cyc=%0d actual=none required=%0h", sb_q[i].name, cyc, sb_q[i].val);
            end else begin
                keep.push_back(sb_q[i]);
            end
        end
        sb_q = keep;
    end

    task automatic expect_at(input int kind, input string name, input logic [7:0] val, input int dly);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beam(input logic [9:0] x, input logic [9:0] y, input logic [9:0] yn, input logic p);
        nes_x      = x;
        nes_y      = y;
        nes_y_next = yn;
        pulse      = p;
    endtask

    task automatic read_px(input logic [9:0] x, input logic [9:0] y, input logic [5:0] exp_v, input string name);
        beam(x, y, y, 1'b0);
        expect_at(K_PIX, name, {2'b00, exp_v}, 1);
        tick();
    endtask

    initial begin
        int xs[7];
        xs = '{0, 1, 5, 63, 64, 200, 255};
        wr_valid = 1'b0;
        wr_idx   = 6'd0;
        beam(10'd300, 10'd1023, 10'd0, 1'b0);
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        expect_at(K_PIX, "rst_pix", 8'h0f, 0);
        expect_at(K_RDY, "rst_ready", 8'd1, 0);
        expect_at(K_UND, "rst_underrun", 8'd0, 0);
        expect_at(K_REQ, "rst_req_y", 8'd0, 0);
        tick();
        read_px(10'd5, 10'd0, 6'h0f, "no_valid_line_pix");

        // Fill line 0 with idx = x[5:0]
        wr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_idx = 6'(i);
            if (i == 0 || i == 255) expect_at(K_RDY, "fill0_ready", 8'd1, 0);
            tick();
        end
        expect_at(K_RDY, "full_ready", 8'd0, 0);
        wr_idx = 6'h3f;
        for (int k = 0; k < 100; k++) begin
            if (k % 25 == 0) expect_at(K_RDY, "full_hold_ready", 8'd0, 0);
            tick();
        end
        wr_valid = 1'b0;

        // Swap into line 0 from the top blanking line (y = -1)
        beam(10'd255, 10'd1023, 10'd0, 1'b1);
        expect_at(K_REQ, "swap0_req_y", 8'd1, 1);
        expect_at(K_UND, "swap0_underrun", 8'd0, 1);
        expect_at(K_PIX, "swap0_pix_blank", 8'h0f, 1);
        tick();
        pulse = 1'b0;
        expect_at(K_RDY, "swap0_ready", 8'd1, 0);
        for (int j = 0; j < 7; j++) read_px(10'(xs[j]), 10'd0, 6'(xs[j]), "line0_pix");
        read_px(10'd300, 10'd0, 6'h0f, "border_x300");
        read_px(10'd10, 10'd1023, 6'h0f, "border_y1023");
        read_px(10'd10, 10'd0, 6'h0a, "line0_x10");

        // Underrun: only 100 pixels before the swap point
        wr_valid = 1'b1;
        wr_idx   = 6'h15;
        for (int i = 0; i < 100; i++) tick();
        wr_valid = 1'b0;
        beam(10'd255, 10'd0, 10'd1, 1'b1);
        expect_at(K_UND, "underrun_pulse", 8'd1, 1);
        expect_at(K_UND, "underrun_clear", 8'd0, 2);
        expect_at(K_REQ, "underrun_req_y", 8'd2, 1);
        expect_at(K_PIX, "underrun_pix255", 8'h3f, 1);
        tick();
        pulse = 1'b0;
        expect_at(K_RDY, "underrun_ready", 8'd1, 0);
        read_px(10'd5, 10'd1, 6'h05, "underrun_old_x5");
        read_px(10'd200, 10'd1, 6'h08, "underrun_old_x200");

        // Counter restarted: exactly 256 more writes fill the bank
        wr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_idx = 6'(63 - (i % 64));
            if (i == 255) expect_at(K_RDY, "restart_ready_255", 8'd1, 0);
            tick();
        end
        wr_valid = 1'b0;
        expect_at(K_RDY, "restart_ready_256", 8'd0, 0);

        // Wrap: swap at nes_y_next = 239
        beam(10'd255, 10'd238, 10'd239, 1'b1);
        expect_at(K_REQ, "wrap_req_y", 8'd0, 1);
        expect_at(K_UND, "wrap_underrun", 8'd0, 1);
        tick();
        pulse = 1'b0;
        expect_at(K_RDY, "wrap_ready", 8'd1, 0);
        read_px(10'd0, 10'd239, 6'd63, "wrap_x0");
        read_px(10'd255, 10'd239, 6'd0, "wrap_x255");
        read_px(10'd100, 10'd239, 6'd27, "wrap_x100");

        wr_valid = 1'b1;
        wr_idx   = 6'h21;
        for (int i = 0; i < 256; i++) tick();
        wr_valid = 1'b0;

        // No swaps while nes_y_next >= 240
        beam(10'd255, 10'd239, 10'd240, 1'b1);
        expect_at(K_REQ, "blank240_req_y", 8'd0, 1);
        expect_at(K_RDY, "blank240_ready", 8'd0, 1);
        expect_at(K_UND, "blank240_underrun", 8'd0, 1);
        tick();
        pulse = 1'b0;
        beam(10'd255, 10'd240, 10'd241, 1'b1);
        expect_at(K_REQ, "blank241_req_y", 8'd0, 1);
        expect_at(K_RDY, "blank241_ready", 8'd0, 1);
        expect_at(K_PIX, "blank241_pix", 8'h0f, 1);
        tick();
        pulse = 1'b0;
        read_px(10'd0, 10'd239, 6'd63, "noswap_x0");

        // Next frame swap
        beam(10'd255, 10'd1023, 10'd0, 1'b1);
        expect_at(K_REQ, "frame2_req_y", 8'd1, 1);
        expect_at(K_UND, "frame2_underrun", 8'd0, 1);
        tick();
        pulse = 1'b0;
        expect_at(K_RDY, "frame2_ready", 8'd1, 0);
        read_px(10'd7, 10'd0, 6'h21, "frame2_x7");

        // 256th write on the swap-point clock
        wr_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            wr_idx = 6'(i + 3);
            tick();
        end
        wr_idx = 6'd2;
        beam(10'd255, 10'd0, 10'd1, 1'b1);
        expect_at(K_UND, "simul_underrun", 8'd0, 1);
        expect_at(K_UND, "simul_underrun_after", 8'd0, 2);
        expect_at(K_REQ, "simul_req_y", 8'd2, 1);
        tick();
        wr_valid = 1'b0;
        pulse    = 1'b0;
        expect_at(K_RDY, "simul_ready", 8'd1, 0);
        read_px(10'd255, 10'd1, 6'd2, "simul_x255");
        read_px(10'd0, 10'd1, 6'd3, "simul_x0");
        read_px(10'd10, 10'd1, 6'd13, "simul_x10");

        // Reset mid-line
        wr_valid = 1'b1;
        wr_idx   = 6'd1;
        for (int i = 0; i < 50; i++) tick();
        rst = 1'b1;
        expect_at(K_PIX, "midrst_pix", 8'h0f, 0);
        expect_at(K_RDY, "midrst_ready", 8'd1, 0);
        expect_at(K_REQ, "midrst_req_y", 8'd0, 0);
        expect_at(K_UND, "midrst_underrun", 8'd0, 0);
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        read_px(10'd10, 10'd1, 6'h0f, "postrst_pix_a");
        read_px(10'd20, 10'd1, 6'h0f, "postrst_pix_b");

        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
